// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID and EX stages: opcodes, immediate
// formats, the control-bit bundle and the decode helpers built on them.
package id_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(6'b000000);

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                     fmt = IMM_S;
      OPC_BRANCH:                    fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:            fmt = IMM_U;
      OPC_JAL:                       fmt = IMM_J;
      default:                       fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // A write to x0 is architecturally a no-op, so regWrite is suppressed for rd=0.
  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode, input logic [4:0] rd);
    ctrl_t c;
    c = CTRL_NONE;
    case (opcode)
      OPC_OP: c.reg_write = (rd != 5'd0);
      OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
        c.reg_write = (rd != 5'd0);
        c.alu_src   = 1'b1;
      end
      OPC_LOAD: begin
        c.reg_write = (rd != 5'd0);
        c.mem_read  = 1'b1;
        c.alu_src   = 1'b1;
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OPC_BRANCH: c.branch = 1'b1;
      OPC_JAL, OPC_JALR: begin
        c.reg_write = (rd != 5'd0);
        c.jump      = 1'b1;
        c.alu_src   = 1'b1;
      end
      default: c = CTRL_NONE;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    logic used;
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: used = 1'b1;
      default:                       used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: two combinational read ports with
// write-through from the same-cycle write port; x0 is hardwired to zero.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] mem_r [32];

  function automatic logic [31:0] read_port(
    input logic [4:0]  addr,
    input logic [31:0] stored,
    input logic        wr_en,
    input logic [4:0]  wr_addr,
    input logic [31:0] wr_data
  );
    logic [31:0] value;
    if (addr == 5'd0) begin
      value = 32'h0000_0000;
    end else if (wr_en && (wr_addr == addr)) begin
      value = wr_data;
    end else begin
      value = stored;
    end
    return value;
  endfunction

  // Register storage: synchronous clear, single write port, x0 never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (we && (waddr != 5'd0)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read ports with bypass of the write that lands on this edge.
  always_comb begin
    rdata1 = read_port(raddr1, mem_r[raddr1], we, waddr, wdata);
    rdata2 = read_port(raddr2, mem_r[raddr2], we, waddr, wdata);
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, decode and register read, load-use
// stall detection, and the ID/EX pipeline register feeding the EX stage.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] instruction,
  input  logic        isBranchTaken,
  input  logic        wbEnable,
  input  logic [4:0]  wbRd,
  input  logic [31:0] wbData,
  output logic        stall,
  output logic        exValid,
  output logic [31:0] exPC,
  output logic [31:0] exRs1Data,
  output logic [31:0] exRs2Data,
  output logic [31:0] exImm,
  output logic [4:0]  exRs1,
  output logic [4:0]  exRs2,
  output logic [4:0]  exRd,
  output logic [2:0]  exFunct3,
  output logic        exFunct7b5,
  output logic [6:0]  exOpcode,
  output logic        exRegWrite,
  output logic        exMemRead,
  output logic        exMemWrite,
  output logic        exBranch,
  output logic        exJump,
  output logic        exAluSrc
);

  logic        ifid_valid_r;
  logic [31:0] ifid_pc_r;
  logic [31:0] ifid_instr_r;

  logic [6:0]  opcode_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [4:0]  rd_s;
  imm_fmt_e    fmt_s;
  logic [31:0] imm_s;
  ctrl_t       ctrl_s;
  logic [31:0] rs1_data_s;
  logic [31:0] rs2_data_s;
  logic        hazard_s;
  logic        kill_s;
  ctrl_t       ex_ctrl_r;

  assign opcode_s = ifid_instr_r[6:0];
  assign rd_s     = ifid_instr_r[11:7];
  assign rs1_s    = ifid_instr_r[19:15];
  assign rs2_s    = ifid_instr_r[24:20];

  // Immediate and control decode of the instruction held in IF/ID.
  always_comb begin
    fmt_s  = imm_fmt(opcode_s);
    imm_s  = gen_imm(ifid_instr_r, fmt_s);
    ctrl_s = decode_ctrl(opcode_s, rd_s);
  end

  regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs1_s),
    .raddr2 (rs2_s),
    .rdata1 (rs1_data_s),
    .rdata2 (rs2_data_s),
    .we     (wbEnable),
    .waddr  (wbRd),
    .wdata  (wbData)
  );

  // Load-use hazard: the load in EX cannot forward in time to this consumer.
  always_comb begin
    hazard_s = 1'b0;
    if (!reset && ifid_valid_r && exValid && ex_ctrl_r.mem_read && (exRd != 5'd0)) begin
      hazard_s = (exRd == rs1_s) || ((exRd == rs2_s) && uses_rs2(opcode_s));
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign stall  = hazard_s;
  assign kill_s = isBranchTaken || hazard_s || !ifid_valid_r;

  // IF/ID register: a flush wins over a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid_r <= 1'b0;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_instr_r <= 32'h0000_0000;
    end else if (isBranchTaken) begin
      ifid_valid_r <= 1'b0;
    end else if (!hazard_s) begin
      ifid_valid_r <= 1'b1;
      ifid_pc_r    <= PC;
      ifid_instr_r <= instruction;
    end
  end

  // ID/EX register: bubbles, flushes and invalid entries all load an all-zero slot.
  always_ff @(posedge clk) begin
    if (reset || kill_s) begin
      exValid    <= 1'b0;
      exPC       <= 32'h0000_0000;
      exRs1Data  <= 32'h0000_0000;
      exRs2Data  <= 32'h0000_0000;
      exImm      <= 32'h0000_0000;
      exRs1      <= 5'd0;
      exRs2      <= 5'd0;
      exRd       <= 5'd0;
      exFunct3   <= 3'd0;
      exFunct7b5 <= 1'b0;
      exOpcode   <= 7'd0;
      ex_ctrl_r  <= CTRL_NONE;
    end else begin
      exValid    <= 1'b1;
      exPC       <= ifid_pc_r;
      exRs1Data  <= rs1_data_s;
      exRs2Data  <= rs2_data_s;
      exImm      <= imm_s;
      exRs1      <= rs1_s;
      exRs2      <= rs2_s;
      exRd       <= rd_s;
      exFunct3   <= ifid_instr_r[14:12];
      exFunct7b5 <= ifid_instr_r[30];
      exOpcode   <= opcode_s;
      ex_ctrl_r  <= ctrl_s;
    end
  end

  assign exRegWrite = ex_ctrl_r.reg_write;
  assign exMemRead  = ex_ctrl_r.mem_read;
  assign exMemWrite = ex_ctrl_r.mem_write;
  assign exBranch   = ex_ctrl_r.branch;
  assign exJump     = ex_ctrl_r.jump;
  assign exAluSrc   = ex_ctrl_r.alu_src;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus random traffic,
// compared every cycle against a behavioural pipeline model.
module tb_id_stage;

  localparam logic [6:0] LOAD = 7'b0000011, OPIMM = 7'b0010011, AUIPC = 7'b0010111;
  localparam logic [6:0] STORE = 7'b0100011, OP = 7'b0110011, LUI = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011, JALR = 7'b1100111, JAL = 7'b1101111;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LW_X5 = 32'h0001_2283;   // lw  x5,0(x2)
  localparam logic [31:0] ADD_X6 = 32'h0012_8333;  // add x6,x5,x1

  logic        clk = 1'b0;
  logic        reset, isBranchTaken, wbEnable;
  logic [31:0] PC, instruction, wbData;
  logic [4:0]  wbRd;
  logic        stall, exValid, exFunct7b5;
  logic [31:0] exPC, exRs1Data, exRs2Data, exImm;
  logic [4:0]  exRs1, exRs2, exRd;
  logic [2:0]  exFunct3;
  logic [6:0]  exOpcode;
  logic        exRegWrite, exMemRead, exMemWrite, exBranch, exJump, exAluSrc;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  id_stage dut (
    .clk(clk), .reset(reset), .PC(PC), .instruction(instruction),
    .isBranchTaken(isBranchTaken), .wbEnable(wbEnable), .wbRd(wbRd), .wbData(wbData),
    .stall(stall), .exValid(exValid), .exPC(exPC), .exRs1Data(exRs1Data),
    .exRs2Data(exRs2Data), .exImm(exImm), .exRs1(exRs1), .exRs2(exRs2), .exRd(exRd),
    .exFunct3(exFunct3), .exFunct7b5(exFunct7b5), .exOpcode(exOpcode),
    .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exBranch(exBranch), .exJump(exJump), .exAluSrc(exAluSrc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [6:0]  op;
    logic        rw, mr, mw, br, jp, as;
  } ex_t;

  logic [31:0] m_regs [32];
  logic        m_ifv;
  logic [31:0] m_ifpc, m_ifin;
  ex_t         m_ex;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Immediate value by plain integer arithmetic on the instruction fields.
  function automatic logic [31:0] m_imm(input logic [31:0] in);
    int t;
    int v;
    v = 0;
    if (in[6:0] inside {LOAD, OPIMM, JALR}) begin
      t = $signed(in[31:20]);
      v = t;
    end else if (in[6:0] == STORE) begin
      t = $signed(in[31:25]);
      v = t * 32 + int'(in[11:7]);
    end else if (in[6:0] == BRANCH) begin
      t = $signed(in[31:31]);
      v = t * 4096 + int'(in[7]) * 2048 + int'(in[30:25]) * 32 + int'(in[11:8]) * 2;
    end else if (in[6:0] inside {LUI, AUIPC}) begin
      v = int'(in[31:12]) * 4096;
    end else if (in[6:0] == JAL) begin
      t = $signed(in[31:31]);
      v = t * 1048576 + int'(in[19:12]) * 4096 + int'(in[20]) * 2048 + int'(in[30:21]) * 2;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 5'd0) return 32'h0;
    if (we && wrd == idx) return wd;
    return m_regs[idx];
  endfunction

  function automatic bit m_stall(input logic rst);
    bit hit;
    hit = (m_ex.rd == m_ifin[19:15]) ||
          (m_ex.rd == m_ifin[24:20] && (m_ifin[6:0] inside {OP, STORE, BRANCH}));
    return !rst && m_ex.v && m_ex.mr && m_ex.rd != 5'd0 && m_ifv && hit;
  endfunction

  function automatic ex_t m_decode(input logic [31:0] pc, input logic [31:0] in, input logic we,
                                   input logic [4:0] wrd, input logic [31:0] wd);
    ex_t e;
    logic [6:0] op;
    op = in[6:0];
    e = '{default: '0};
    e.v = 1'b1;   e.pc = pc;        e.imm = m_imm(in);
    e.rs1 = in[19:15]; e.rs2 = in[24:20]; e.rd = in[11:7];
    e.f3 = in[14:12];  e.f7 = in[30];     e.op = op;
    e.d1 = m_read(in[19:15], we, wrd, wd);
    e.d2 = m_read(in[24:20], we, wrd, wd);
    e.mr = (op == LOAD);
    e.mw = (op == STORE);
    e.br = (op == BRANCH);
    e.jp = op inside {JAL, JALR};
    e.rw = (op inside {OP, OPIMM, LOAD, LUI, AUIPC, JAL, JALR}) && e.rd != 5'd0;
    e.as = op inside {OPIMM, LOAD, JALR, STORE, LUI, AUIPC, JAL};
    return e;
  endfunction

  // Advance the model over one clock edge using the inputs present at that edge.
  task automatic m_step();
    bit s;
    s = m_stall(reset);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_ifv = 1'b0; m_ifpc = 32'h0; m_ifin = 32'h0;
      m_ex = '{default: '0};
    end else begin
      if (!isBranchTaken && !s && m_ifv) m_ex = m_decode(m_ifpc, m_ifin, wbEnable, wbRd, wbData);
      else m_ex = '{default: '0};
      if (isBranchTaken) m_ifv = 1'b0;
      else if (!s) begin
        m_ifv = 1'b1; m_ifpc = PC; m_ifin = instruction;
      end
      if (wbEnable && wbRd != 5'd0) m_regs[wbRd] = wbData;
    end
  endtask

  // Compare process: every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      chk("stall", {31'd0, stall}, {31'd0, m_stall(reset)});
      chk("exValid", {31'd0, exValid}, {31'd0, m_ex.v});
      chk("exPC", exPC, m_ex.pc);
      chk("exRs1Data", exRs1Data, m_ex.d1);
      chk("exRs2Data", exRs2Data, m_ex.d2);
      chk("exImm", exImm, m_ex.imm);
      chk("exRs1", {27'd0, exRs1}, {27'd0, m_ex.rs1});
      chk("exRs2", {27'd0, exRs2}, {27'd0, m_ex.rs2});
      chk("exRd", {27'd0, exRd}, {27'd0, m_ex.rd});
      chk("exFunct3", {29'd0, exFunct3}, {29'd0, m_ex.f3});
      chk("exFunct7b5", {31'd0, exFunct7b5}, {31'd0, m_ex.f7});
      chk("exOpcode", {25'd0, exOpcode}, {25'd0, m_ex.op});
      chk("ctrl", {26'd0, exRegWrite, exMemRead, exMemWrite, exBranch, exJump, exAluSrc},
          {26'd0, m_ex.rw, m_ex.mr, m_ex.mw, m_ex.br, m_ex.jp, m_ex.as});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_step();
    armed = 1'b1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] in, input logic bt,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    reset = 1'b0; PC = pc; instruction = in; isBranchTaken = bt;
    wbEnable = we; wbRd = wrd; wbData = wd;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [10];
    ops = '{LOAD, LOAD, OPIMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    drive(32'h0, NOP, 1'b0, 1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    chk("reset exValid", {31'd0, exValid}, 32'd0);
    chk("reset exImm", exImm, 32'h0);
    chk("reset exRegWrite", {31'd0, exRegWrite}, 32'd0);

    // addi x1,x0,5 two cycles to ID/EX
    drive(32'h0, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'h0);
    #1 chk("stall after reset", {31'd0, stall}, 32'd0);
    tick();
    drive(32'h4, NOP, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("addi exValid", {31'd0, exValid}, 32'd1);
    chk("addi exImm", exImm, 32'h0000_0005);
    chk("addi exRd", {27'd0, exRd}, 32'd1);
    chk("addi exRegWrite", {31'd0, exRegWrite}, 32'd1);
    chk("addi exAluSrc", {31'd0, exAluSrc}, 32'd1);

    // write-through: add x4,x3,x0 reads x3 while it is being written
    drive(32'h8, 32'h0001_8233, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'hC, NOP, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    tick();
    chk("wt exRs1Data", exRs1Data, 32'hDEAD_BEEF);

    // load-use: one stall, one bubble, then the add
    drive(32'h100, LW_X5, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h104, ADD_X6, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("lu stall", {31'd0, stall}, 32'd1);
    drive(32'h108, NOP, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("lu bubble", {31'd0, exValid}, 32'd0);
    chk("lu stall once", {31'd0, stall}, 32'd0);
    tick();
    chk("lu add valid", {31'd0, exValid}, 32'd1);
    chk("lu add rs1", {27'd0, exRs1}, 32'd5);
    chk("lu add pc", exPC, 32'h104);

    // flush during a load-use stall
    drive(32'h200, LW_X5, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h204, ADD_X6, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h208, NOP, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h20C, NOP, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("flush exValid", {31'd0, exValid}, 32'd0);
    chk("flush stall", {31'd0, stall}, 32'd0);
    tick();
    chk("flush ifid invalid", {31'd0, exValid}, 32'd0);

    // beq -8 and JAL +2048
    drive(32'h300, 32'hFE00_0CE3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h304, 32'h0010_00EF, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("beq exImm", exImm, 32'hFFFF_FFF8);
    chk("beq exBranch", {31'd0, exBranch}, 32'd1);
    drive(32'h308, NOP, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("jal exImm", exImm, 32'h0000_0800);
    chk("jal exJump", {31'd0, exJump}, 32'd1);

    // x0 ignores writes, including the write-through path
    drive(32'h400, 32'h0000_03B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h404, NOP, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
    tick();
    chk("x0 wt", exRs1Data, 32'h0);
    drive(32'h408, 32'h0000_03B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h40C, NOP, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("x0 read", exRs1Data, 32'h0);

    // reset mid-stream with a pending load-use stall
    drive(32'h500, LW_X5, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h504, ADD_X6, 1'b0, 1'b1, 5'd9, 32'h5555_AAAA);
    reset = 1'b1;
    #1 chk("stall in reset", {31'd0, stall}, 32'd0);
    tick();
    chk("rst exValid", {31'd0, exValid}, 32'd0);
    chk("rst exPC", exPC, 32'h0);
    chk("rst exImm", exImm, 32'h0);
    chk("rst exMemRead", {31'd0, exMemRead}, 32'd0);
    chk("rst exRd", {27'd0, exRd}, 32'd0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      drive($urandom, rand_instr(), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The module SHALL have the ports listed below; one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- PC  in  32  fetch-stage PC of the current instruction
- instruction  in  32  fetch-stage instruction word
- isBranchTaken  in  1  redirect from EX; squashes younger instructions
- wbEnable  in  1  register-file write strobe
- wbRd  in  5  write-back destination
- wbData  in  32  write-back data
- stall  out  1  combinational; holds the fetch PC this cycle
- exValid  out  1  ID/EX entry valid
- exPC  out  32  PC of ID/EX entry
- exRs1Data, exRs2Data  out  32 each  operand values
- exImm  out  32  sign-extended immediate
- exRs1, exRs2, exRd  out  5 each  register indices
- exFunct3  out  3  instruction[14:12]
- exFunct7b5  out  1  instruction[30]
- exOpcode  out  7  instruction[6:0]
- exRegWrite, exMemRead, exMemWrite, exBranch, exJump, exAluSrc  out  1 each  control bits

Function
REQ-002 The IF/ID register SHALL capture PC, instruction and valid=1 on each rising edge unless stall=1 (hold) or isBranchTaken=1 (valid←0).
REQ-003 Decode, immediate generation and register read SHALL be combinational from the IF/ID register; results SHALL be captured into the ID/EX register on the next edge (input-to-exValid latency: 2 cycles).
REQ-004 Immediate formats by opcode: I (0000011, 0010011, 1100111), S (0100011), B (1100011, bit0=0), U (0110111, 0010111, low 12 bits zero), J (1101111, bit0=0); R-type and unknown opcodes SHALL give exImm=0.
REQ-005 Control: regWrite for R/I/load/LUI/AUIPC/JAL/JALR with rd≠0; memRead for load only; memWrite for store only; branch for 1100011; jump for JAL/JALR; aluSrc for all non-R, non-B formats.
REQ-006 Unknown opcode SHALL decode as a valid entry with all control bits 0.
REQ-007 Register file: 32×32; x0 reads 0 and ignores writes; a write takes effect on the rising edge.
REQ-008 Write-through: when wbEnable=1 and wbRd≠0 equals the rs1/rs2 being read in the same cycle, the read SHALL return wbData.
REQ-009 Load-use: stall=1 when exValid & exMemRead & exRd≠0 & IF/ID valid & (exRd==rs1 or (exRd==rs2 and the format uses rs2: R/S/B)).
REQ-010 On a stall the ID/EX register SHALL load a bubble (exValid=0, all control bits 0) and IF/ID SHALL hold; a stall lasts exactly one cycle per load.
REQ-011 isBranchTaken SHALL clear both IF/ID valid and exValid on the same edge; flush overrides stall; a register-file write in that cycle SHALL still occur.
REQ-012 An invalid IF/ID entry SHALL produce exValid=0 with control bits 0; it SHALL never assert stall.

Reset
REQ-013 On reset: IF/ID valid=0, exValid=0, all ex* data/control outputs=0, all 32 registers=0; reset overrides flush, stall and write-back.
REQ-014 stall SHALL be 0 during and in the first cycle after reset.

Structure
REQ-015 Opcode constants, immediate-format encoding and the control-bit bundle SHALL live in a shared package used by id_stage and the later EX stage.
REQ-016 The register file SHALL be a separate sub-module, regfile (two combinational read ports, one synchronous write port, write-through).

Verification
REQ-017 After reset, feed addi x1,x0,5 (0x00500093) at PC=0 -> 2 cycles later exValid=1, exImm=5, exRd=1, exRegWrite=1, exAluSrc=1.
REQ-018 wbEnable=1, wbRd=3, wbData=0xDEADBEEF while add x4,x3,x0 sits in IF/ID -> exRs1Data=0xDEADBEEF on the next edge.
REQ-019 lw x5,0(x2) followed by add x6,x5,x1 -> stall=1 for one cycle, one bubble (exValid=0), add issues next cycle with exRs1=5.
REQ-020 isBranchTaken=1 together with a load-use stall -> stall ignored, IF/ID and ID/EX both invalid on the next edge.
REQ-021 beq with offset -8 (0xFE000CE3) -> exImm=0xFFFFFFF8, exBranch=1; JAL offset 2048 -> exImm=0x00000800, exJump=1.
REQ-022 Write wbRd=0 with 0x1234, then read x0 -> 0; assert reset mid-stream -> all ex* outputs 0 next edge.
